// File: rtl/adc_sample_scheduler_if.sv
// Bundle of run controls, ADC front-end signals and the tagged sample stream
// for adc_sample_scheduler. master = scheduler side, slave = environment side.
interface adc_sample_scheduler_if #(
  parameter int NUM_CH = 4,
  parameter int CH_W   = 2,
  parameter int DATA_W = 12
);
  logic              enable;
  logic [NUM_CH-1:0] ch_mask;
  logic              adc_reset_n;
  logic [CH_W-1:0]   adc_ch;
  logic              adc_data_valid;
  logic [DATA_W-1:0] adc_data;
  logic              sample_valid;
  logic              sample_ready;
  logic [DATA_W-1:0] sample_data;
  logic [CH_W-1:0]   sample_ch;
  logic [7:0]        overrun_count;
  logic [7:0]        timeout_count;
  logic              busy;

  modport master (
    input  enable, ch_mask, adc_data_valid, adc_data, sample_ready,
    output adc_reset_n, adc_ch, sample_valid, sample_data, sample_ch,
           overrun_count, timeout_count, busy
  );

  modport slave (
    output enable, ch_mask, adc_data_valid, adc_data, sample_ready,
    input  adc_reset_n, adc_ch, sample_valid, sample_data, sample_ch,
           overrun_count, timeout_count, busy
  );
endinterface

// File: rtl/adc_sample_scheduler.sv
// Round-robin ADC channel scheduler: one conversion start per PERIOD cycles,
// result capture into a valid/ready stream, overrun and timeout counters.
module adc_sample_scheduler #(
  parameter int PERIOD = 81,
  parameter int NUM_CH = 4,
  parameter int CH_W   = 2,
  parameter int DATA_W = 12
) (
  input  logic                   clock_in,
  input  logic                   reset_in,
  adc_sample_scheduler_if.master bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_START = 2'd2,
    ST_WAIT  = 2'd3
  } state_t;

  localparam logic [15:0] CNT_LAST = 16'(PERIOD - 1);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [15:0]       r_cnt;
  logic [CH_W-1:0]   r_last_ch;
  logic [CH_W-1:0]   r_adc_ch;
  logic              r_adc_reset_n;
  logic              r_busy;
  logic              r_sample_valid;
  logic [DATA_W-1:0] r_sample_data;
  logic [CH_W-1:0]   r_sample_ch;
  logic [7:0]        r_overrun_count;
  logic [7:0]        r_timeout_count;

  logic              w_running;
  logic              w_slot_begin;
  logic              w_capture;
  logic              w_accept;
  logic [CH_W-1:0]   w_next_ch;

  // First set mask bit after 'last', wrapping; the loop runs from the farthest
  // offset down so the nearest candidate is the one left standing.
  function automatic logic [CH_W-1:0] next_channel(input logic [NUM_CH-1:0] mask,
                                                   input logic [CH_W-1:0]   last);
    logic [CH_W-1:0] pick;
    logic [CH_W-1:0] idx;
    pick = last;
    for (int i = NUM_CH; i >= 1; i--) begin
      idx = CH_W'((int'(last) + i) % NUM_CH);
      if (mask[idx]) pick = idx;
    end
    return pick;
  endfunction

  assign w_running    = bus.enable && (bus.ch_mask != {NUM_CH{1'b0}});
  assign w_slot_begin = w_running && (r_cnt == 16'd0);
  assign w_capture    = (r_state == ST_WAIT) && bus.adc_data_valid;
  assign w_accept     = !r_sample_valid || bus.sample_ready;
  assign w_next_ch    = next_channel(bus.ch_mask, r_last_ch);

  // Next-state logic; losing the run request always parks the FSM in IDLE.
  always_comb begin
    w_state_nxt = r_state;
    if (!w_running) begin
      w_state_nxt = ST_IDLE;
    end else if (w_slot_begin) begin
      w_state_nxt = ST_SETUP;
    end else begin
      case (r_state)
        ST_SETUP: w_state_nxt = ST_START;
        ST_START: w_state_nxt = ST_WAIT;
        ST_WAIT:  w_state_nxt = bus.adc_data_valid ? ST_IDLE : ST_WAIT;
        ST_IDLE:  w_state_nxt = ST_IDLE;
        default:  w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // State register, period counter and the ADC-facing outputs.
  always_ff @(posedge clock_in) begin
    if (reset_in) begin
      r_state       <= ST_IDLE;
      r_cnt         <= 16'd0;
      r_adc_reset_n <= 1'b1;
      r_busy        <= 1'b0;
      r_adc_ch      <= {CH_W{1'b0}};
      r_last_ch     <= CH_W'(NUM_CH - 1);
    end else begin
      r_state       <= w_state_nxt;
      r_adc_reset_n <= (w_state_nxt != ST_START);
      r_busy        <= (w_state_nxt != ST_IDLE);
      if (!w_running || r_cnt == CNT_LAST) begin
        r_cnt <= 16'd0;
      end else begin
        r_cnt <= r_cnt + 16'd1;
      end
      if (w_slot_begin) begin
        r_adc_ch  <= w_next_ch;
        r_last_ch <= w_next_ch;
      end
    end
  end

  // Output stream holding register and saturating event counters.
  always_ff @(posedge clock_in) begin
    if (reset_in) begin
      r_sample_valid  <= 1'b0;
      r_sample_data   <= {DATA_W{1'b0}};
      r_sample_ch     <= {CH_W{1'b0}};
      r_overrun_count <= 8'd0;
      r_timeout_count <= 8'd0;
    end else begin
      if (w_capture) begin
        if (w_accept) begin
          r_sample_valid <= 1'b1;
          r_sample_data  <= bus.adc_data;
          r_sample_ch    <= r_adc_ch;
        end else if (r_overrun_count != 8'hFF) begin
          r_overrun_count <= r_overrun_count + 8'd1;
        end
      end else if (r_sample_valid && bus.sample_ready) begin
        r_sample_valid <= 1'b0;
      end
      // A result arriving on the slot-begin edge still counts as an answer.
      if (w_slot_begin && r_state == ST_WAIT && !bus.adc_data_valid &&
          r_timeout_count != 8'hFF) begin
        r_timeout_count <= r_timeout_count + 8'd1;
      end
    end
  end

  assign bus.adc_reset_n   = r_adc_reset_n;
  assign bus.adc_ch        = r_adc_ch;
  assign bus.busy          = r_busy;
  assign bus.sample_valid  = r_sample_valid;
  assign bus.sample_data   = r_sample_data;
  assign bus.sample_ch     = r_sample_ch;
  assign bus.overrun_count = r_overrun_count;
  assign bus.timeout_count = r_timeout_count;

endmodule

// File: tb/tb_adc_sample_scheduler.sv
// Bench for adc_sample_scheduler: cycle-accurate slot-timeline model compared on
// every falling edge, directed scenarios with literal expectations, random phase.
module tb_adc_sample_scheduler;
  localparam int PERIOD = 81;
  localparam int NUM_CH = 4;
  localparam int CH_W   = 2;
  localparam int DATA_W = 12;

  logic clock_in = 1'b0;
  logic reset_in = 1'b1;

  logic              en_s   = 1'b0;
  logic [NUM_CH-1:0] mask_s = '0;
  logic              rdy_s  = 1'b0;
  logic              dv_s   = 1'b0;
  logic [DATA_W-1:0] dat_s  = '0;

  adc_sample_scheduler_if #(.NUM_CH(NUM_CH), .CH_W(CH_W), .DATA_W(DATA_W)) bus ();

  assign bus.enable         = en_s;
  assign bus.ch_mask        = mask_s;
  assign bus.sample_ready   = rdy_s;
  assign bus.adc_data_valid = dv_s;
  assign bus.adc_data       = dat_s;

  adc_sample_scheduler #(.PERIOD(PERIOD), .NUM_CH(NUM_CH), .CH_W(CH_W), .DATA_W(DATA_W)) dut (
    .clock_in (clock_in),
    .reset_in (reset_in),
    .bus      (bus)
  );

  always #5 clock_in = ~clock_in;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  always @(posedge clock_in) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ADC responder: answers resp_delay cycles after it sees the start pulse.
  int                resp_delay = -1;
  int                resp_cnt   = 0;
  bit                stray_en   = 1'b0;
  logic [DATA_W-1:0] last_sent  = '0;
  logic [DATA_W-1:0] sent_q[$];

  always @(negedge clock_in) begin
    dv_s = 1'b0;
    if (bus.adc_reset_n === 1'b0 && resp_delay >= 0) begin
      resp_cnt = resp_delay;
    end else if (resp_cnt > 0) begin
      resp_cnt--;
      if (resp_cnt == 0) begin
        dv_s      = 1'b1;
        dat_s     = DATA_W'($urandom);
        last_sent = dat_s;
        sent_q.push_back(dat_s);
      end
    end else if (stray_en && $urandom_range(0, 49) == 0) begin
      dv_s  = 1'b1;
      dat_s = DATA_W'($urandom);
    end
  end

  // Reference model: timeline measured as cycles since the last slot begin
  // (-1 = nothing outstanding); 2 = start pulse, >=3 = awaiting the ADC.
  bit                m_init = 1'b0;
  int                m_cnt, m_since, m_last, m_ch, m_sch, m_ovr, m_tmo;
  bit                m_valid;
  logic [DATA_W-1:0] m_data;

  function automatic int pick(input logic [NUM_CH-1:0] mask, input int last);
    for (int k = 1; k <= NUM_CH; k++) begin
      int c;
      c = (last + k) % NUM_CH;
      if (mask[c]) return c;
    end
    return last;
  endfunction

  always @(posedge clock_in) begin
    bit run, waiting;
    if (reset_in) begin
      m_cnt = 0; m_since = -1; m_last = NUM_CH - 1; m_ch = 0;
      m_valid = 1'b0; m_data = '0; m_sch = 0; m_ovr = 0; m_tmo = 0;
      m_init = 1'b1;
    end else begin
      run     = en_s && (mask_s != 0);
      waiting = (m_since >= 3);
      if (waiting && dv_s) begin
        if (!m_valid || rdy_s) begin
          m_valid = 1'b1; m_data = dat_s; m_sch = m_ch;
        end else if (m_ovr < 255) begin
          m_ovr++;
        end
        m_since = -1;
      end else if (m_valid && rdy_s) begin
        m_valid = 1'b0;
      end
      if (!run) begin
        m_cnt = 0; m_since = -1;
      end else begin
        if (m_cnt == 0) begin
          if (waiting && !dv_s && m_tmo < 255) m_tmo++;
          m_ch = pick(mask_s, m_last); m_last = m_ch; m_since = 1;
        end else if (m_since >= 1) begin
          m_since++;
        end
        m_cnt = (m_cnt + 1) % PERIOD;
      end
    end
  end

  // Per-cycle comparison of every DUT output against the model.
  always @(negedge clock_in) begin
    if (m_init && !reset_in) begin
      chk("adc_reset_n",   32'(bus.adc_reset_n),   32'(m_since != 2));
      chk("busy",          32'(bus.busy),          32'(m_since != -1));
      chk("adc_ch",        32'(bus.adc_ch),        32'(m_ch));
      chk("sample_valid",  32'(bus.sample_valid),  32'(m_valid));
      chk("overrun_count", 32'(bus.overrun_count), 32'(m_ovr));
      chk("timeout_count", 32'(bus.timeout_count), 32'(m_tmo));
      if (m_valid) begin
        chk("sample_data", 32'(bus.sample_data), 32'(m_data));
        chk("sample_ch",   32'(bus.sample_ch),   32'(m_sch));
      end
    end
  end

  task automatic wait_pulse(output int t, output int ch);
    t = -1; ch = -1;
    for (int i = 0; i < 4 * PERIOD; i++) begin
      @(negedge clock_in);
      if (bus.adc_reset_n === 1'b0) begin
        t = cyc; ch = int'(bus.adc_ch);
        return;
      end
    end
    tests++; fails++;
    $display("FAIL pulse_wait: got no start pulse expected one within %0d cycles", 4 * PERIOD);
  endtask

  initial begin
    int e, t, t_prev, ch;
    int exp_ch[4];

    // Reset values
    repeat (4) @(negedge clock_in);
    chk("rst adc_reset_n",   32'(bus.adc_reset_n),   32'd1);
    chk("rst adc_ch",        32'(bus.adc_ch),        32'd0);
    chk("rst sample_valid",  32'(bus.sample_valid),  32'd0);
    chk("rst sample_data",   32'(bus.sample_data),   32'd0);
    chk("rst sample_ch",     32'(bus.sample_ch),     32'd0);
    chk("rst overrun",       32'(bus.overrun_count), 32'd0);
    chk("rst timeout",       32'(bus.timeout_count), 32'd0);
    chk("rst busy",          32'(bus.busy),          32'd0);

    // Single channel, ADC answers 20 cycles after start
    reset_in = 1'b0; en_s = 1'b1; mask_s = 4'b0001; rdy_s = 1'b1; resp_delay = 20;
    e = cyc;
    t_prev = 0;
    for (int k = 0; k < 4; k++) begin
      wait_pulse(t, ch);
      if (k == 0) chk("first start cycle", 32'(t), 32'(e + 2));
      else        chk("start spacing", 32'(t - t_prev), 32'd81);
      chk("t1 channel", 32'(ch), 32'd0);
      t_prev = t;
    end
    repeat (21) @(negedge clock_in);
    chk("t1 sample_valid", 32'(bus.sample_valid), 32'd1);
    chk("t1 sample_ch",    32'(bus.sample_ch),    32'd0);
    chk("t1 sample_data",  32'(bus.sample_data),  32'(last_sent));
    chk("t1 overrun",      32'(bus.overrun_count), 32'd0);
    chk("t1 timeout",      32'(bus.timeout_count), 32'd0);

    // Channel rotation over mask 1010, then mid-slot mask change
    mask_s = 4'b1010;
    exp_ch[0] = 1; exp_ch[1] = 3; exp_ch[2] = 1; exp_ch[3] = 3;
    for (int k = 0; k < 4; k++) begin
      wait_pulse(t, ch);
      chk("t2 rotation", 32'(ch), 32'(exp_ch[k]));
    end
    repeat (30) @(negedge clock_in);
    mask_s = 4'b0100;
    wait_pulse(t, ch);
    chk("t2 mask change", 32'(ch), 32'd2);

    // Downstream stall for five slots
    rdy_s = 1'b0;
    sent_q.delete();
    for (int k = 0; k < 4; k++) wait_pulse(t, ch);
    repeat (22) @(negedge clock_in);
    chk("t3 overrun",      32'(bus.overrun_count), 32'd4);
    chk("t3 held data",    32'(bus.sample_data),   32'(sent_q[0]));
    chk("t3 held ch",      32'(bus.sample_ch),     32'd2);
    chk("t3 held valid",   32'(bus.sample_valid),  32'd1);
    rdy_s = 1'b1;
    @(negedge clock_in);
    chk("t3 valid cleared", 32'(bus.sample_valid), 32'd0);

    // Enable dropped five cycles into WAIT; late strobe must be ignored
    resp_delay = 15;
    wait_pulse(t, ch);
    sent_q.delete();
    repeat (5) @(negedge clock_in);
    en_s = 1'b0;
    @(negedge clock_in);
    chk("t4 busy",        32'(bus.busy),        32'd0);
    chk("t4 adc_reset_n", 32'(bus.adc_reset_n), 32'd1);
    repeat (12) @(negedge clock_in);
    chk("t4 strobe sent",   32'(sent_q.size()),      32'd1);
    chk("t4 no capture",    32'(bus.sample_valid),   32'd0);
    chk("t4 timeout",       32'(bus.timeout_count),  32'd0);

    // Transfer and reload in the same cycle
    en_s = 1'b1; rdy_s = 1'b0; resp_delay = 10;
    wait_pulse(t, ch);
    wait_pulse(t, ch);
    repeat (10) @(negedge clock_in);
    rdy_s = 1'b1;
    @(negedge clock_in);
    chk("t5 valid kept",  32'(bus.sample_valid),  32'd1);
    chk("t5 new data",    32'(bus.sample_data),   32'(last_sent));
    chk("t5 overrun",     32'(bus.overrun_count), 32'd4);
    @(negedge clock_in);
    chk("t5 drained",     32'(bus.sample_valid),  32'd0);

    // Randomized phase, checked only against the model
    stray_en = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clock_in);
      rdy_s = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 199) == 0) mask_s = NUM_CH'($urandom);
      if ($urandom_range(0, 499) == 0) en_s = !en_s;
      if ($urandom_range(0, 99) == 0)  resp_delay = int'($urandom_range(1, 60));
    end
    stray_en = 1'b0; en_s = 1'b1; rdy_s = 1'b1;
    mask_s = NUM_CH'($urandom_range(1, 15));

    // Silent ADC: timeouts accumulate and saturate
    resp_delay = -1; resp_cnt = 0;
    for (int k = 0; k < 300; k++) wait_pulse(t, ch);
    repeat (5) @(negedge clock_in);
    chk("t6 timeout sat", 32'(bus.timeout_count), 32'd255);
    chk("t6 no sample",   32'(bus.sample_valid),  32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/adc_sample_scheduler.md
# adc_sample_scheduler

Sequences the power-monitor ADC across multiple input channels. Generates one conversion-start pulse per fixed sample period on the active-low ADC start/reset line, selects the channel before each start, and captures the returned conversion result. Results are presented on a valid/ready stream tagged with channel number. Overruns (downstream stall) and timeouts (ADC silent for a whole period) are counted. Sits between the ADC front end and the power-computation datapath.

## Interface
- PERIOD, 81: clock cycles per sample slot (50 MHz → 617 kSps per slot); legal range 4..65535
- NUM_CH, 4: number of multiplexed channels (2..16)
- CH_W, 2: channel index width, clog2(NUM_CH)
- DATA_W, 12: ADC result width

- clock_in  in  1  single system clock, all logic on rising edge
- reset_in  in  1  synchronous, active-high reset
- enable  in  1  run request
- ch_mask  in  NUM_CH  enabled channels; sampled at slot begin
- adc_reset_n  out  1  registered; low for exactly one cycle = conversion start
- adc_ch  out  CH_W  registered channel select to ADC mux
- adc_data_valid  in  1  one-cycle strobe, ADC result ready
- adc_data  in  DATA_W  ADC result, qualified by adc_data_valid
- sample_valid  out  1  output stream valid
- sample_ready  in  1  output stream ready
- sample_data  out  DATA_W  captured result
- sample_ch  out  CH_W  channel of sample_data
- overrun_count  out  8  saturating count of dropped results
- timeout_count  out  8  saturating count of unanswered conversions
- busy  out  1  state != IDLE

## Operation
- running = enable && (ch_mask != 0).
- Period counter counts 0..PERIOD-1 and wraps while running. It is forced to 0 whenever running = 0.
- Slot begin = running && counter == 0.
- FSM states: IDLE, SETUP, START, WAIT.
  - Slot begin, any state: adc_ch <= next channel; state <= SETUP. If state was WAIT with no adc_data_valid this cycle, timeout_count += 1.
  - SETUP: mux settle cycle; → START.
  - START: adc_reset_n = 0; → WAIT.
  - WAIT: adc_reset_n = 1. On adc_data_valid, capture the result; → IDLE.
  - IDLE: adc_reset_n = 1; waits for slot begin.
- Next channel: first set bit of ch_mask, scanning cyclically from last_ch+1. Wraps from NUM_CH-1 to 0. last_ch updates to the chosen channel.
- Capture in WAIT:
  - If !sample_valid or sample_ready: sample_data <= adc_data, sample_ch <= adc_ch, sample_valid <= 1.
  - Otherwise: drop the new result, keep the held sample, overrun_count += 1.
- adc_data_valid outside WAIT is ignored.
- Handshake: sample_valid stays high until sample_valid && sample_ready. sample_data and sample_ch are stable while valid && !ready. A transfer without a new capture clears sample_valid the next cycle.
- running falls in any state: next state IDLE, adc_reset_n = 1, counter = 0. No timeout is counted. The held sample and its valid are retained.
- Both counters saturate at 255 and clear only on reset.

## Timing
- Reset values:
  - adc_reset_n = 1, adc_ch = 0, sample_valid = 0, sample_data = 0, sample_ch = 0
  - overrun_count = 0, timeout_count = 0, busy = 0
  - state IDLE, counter 0, last_ch = NUM_CH-1, so the first pick is the lowest set bit
- Slot begin at cycle c:
  - adc_ch valid at c+1 (SETUP).
  - adc_reset_n low during c+2 only (START).
  - WAIT from c+3.
- Start pulses repeat every PERIOD cycles while running.
- Capture latency: adc_data_valid at cycle t gives sample_valid/sample_data at t+1.
- Simultaneous events:
  - Slot begin and adc_data_valid in WAIT, same cycle: the result is captured, no timeout is counted, and the FSM goes to SETUP.
  - sample_ready and adc_data_valid with sample_valid = 1, same cycle: transfer plus reload, no overrun, sample_valid stays 1.
- Mask change: takes effect at the next slot begin only.

## Test plan
- Reset; enable = 1, mask = 0001, ADC model answers 20 cycles after start, ready = 1. Required: adc_reset_n low 1 cycle at counter-zero+2, every 81 cycles; sample_ch = 0; sample_data equals model value; counts stay 0.
- Mask = 1010. Required: adc_ch sequence 1,3,1,3. Change mask to 0100 mid-slot: next slot selects 2.
- ready = 0 held for 5 slots. Required: first sample held unchanged, overrun_count = 4. Raise ready: one transfer, sample_valid low next cycle.
- ADC model silent for 300 slots. Required: timeout_count increments at each slot begin after the first, saturates at 255; no sample_valid.
- enable dropped 5 cycles into WAIT, model strobes adc_data_valid 10 cycles later. Required: IDLE next cycle, busy = 0, adc_reset_n = 1, strobe ignored, timeout_count unchanged.
- sample_valid = 1, sample_ready and adc_data_valid in the same cycle. Required: overrun_count unchanged, new data presented next cycle with sample_valid still 1.
